wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//   Two-master Wishbone round-robin arbiter between the per-CPU Wishbone master
//   adapters and the shared slave bus of the memory slaves.
//   - Registered grant; bus held for the whole cycle while the owner keeps cyc high.
//   - Muxes the owner's adr/dat/we/stb/cyc onto the shared bus.
//   - Returns the slave ack to the owner only.
//   - Read data bypasses the block: the slave bus dat is wired straight to both masters.
// PARAMETERS
//   AW       16  address width
//   DW       8   data width
//   TIMEOUT  16  cycles of stb without ack before abort (used only with ARB_TIMEOUT_EN)
// PORTS
//   clk       in   1   system clock; everything samples on posedge
//   reset_n   in   1   asynchronous, active-low reset
//   m0_adr_i  in   AW  master 0 address
//   m0_dat_i  in   DW  master 0 write data
//   m0_we_i   in   1   master 0 write enable
//   m0_stb_i  in   1   master 0 strobe
//   m0_cyc_i  in   1   master 0 cycle (bus request)
//   m0_ack_o  out  1   ack to master 0
//   m0_err_o  out  1   timeout abort to master 0 (0 when ARB_TIMEOUT_EN undefined)
//   m1_*             same set as m0_* for master 1
//   s_adr_o   out  AW  shared bus address
//   s_dat_o   out  DW  shared bus write data
//   s_we_o    out  1   shared bus write enable
//   s_stb_o   out  1   shared bus strobe
//   s_cyc_o   out  1   shared bus cycle
//   s_ack_i   in   1   OR of all slave acks
//   gnt_o     out  2   one-hot current owner; 00 = idle
// BEHAVIOUR
//   Reset:
//   - reset_n low clears state to IDLE and last_gnt to 1 (master 0 wins first).
//   - Clears the timeout counter.
//   - All outputs 0 immediately, without waiting for clk.
//   FSM, registered: IDLE, OWN0, OWN1.
//   - IDLE: if both cyc are high, grant the master that is not last_gnt. Otherwise
//     grant whichever master requests; stay in IDLE if none.
//   - OWNx: stay while mx_cyc_i is high.
//   - When mx_cyc_i drops, go next edge to OWNy if my_cyc_i is high, else IDLE.
//     This gives zero idle cycles between back-to-back owners.
//   - last_gnt updates on every entry into OWNx.
//   Latency:
//   - Grant appears 1 cycle after cyc rises.
//   - The s_* mux is combinational from the registered grant.
//   - In IDLE, all s_* outputs are 0.
//   - s_*_o = owner's inputs. s_cyc_o = owner cyc. s_stb_o = owner cyc & owner stb.
//   Ack routing:
//   - mx_ack_o = s_ack_i & gnt_o[x] & mx_stb_i.
//   - The non-owner always sees ack = 0.
//   - A master dropping cyc mid-transfer releases the bus on the same edge. Any late
//     s_ack_i is ignored.
//   - No preemption: a waiting master never interrupts the owner.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//   - A counter runs while the owner's stb is high and s_ack_i is low. It clears on ack,
//     on a grant change, or on stb low.
//   - When the count reaches TIMEOUT-1, pulse mx_err_o for 1 cycle.
//   - Force the owner's s_cyc_o/s_stb_o to 0 that cycle.
//   - Move the grant as if cyc had dropped. The master must drop cyc before it can
//     request again.
//   ARB_TIMEOUT_EN undefined:
//   - Counter not instantiated; m0_err_o = m1_err_o = 0; a hung slave blocks the bus.
// STRUCTURE
//   Package wb_arb_pkg:
//   - state typedef/localparams ARB_IDLE=2'd0, ARB_OWN0=2'd1, ARB_OWN1=2'd2;
//   - default AW/DW constants.
//   Sub-module wb_arb_timeout (counter + err pulse), instantiated only under ARB_TIMEOUT_EN.
//   Top level holds the FSM, last_gnt and the output mux.
// TESTING
//   1 Only m0_cyc=stb=1, adr=16'h1005 -> gnt_o=01 after 1 edge; s_adr_o=16'h1005;
//     s_ack_i pulse reaches m0_ack_o only; m1_ack_o=0.
//   2 After reset both cyc rise together -> OWN0 first; m0 drops cyc -> gnt_o=10 on
//     the next edge, no idle cycle.
//   3 m0 and m1 hold requests continuously, each single-beat -> grants strictly
//     alternate 01,10,01,10.
//   4 reset_n low mid-write (gnt_o=10, we=1) -> s_cyc_o=s_stb_o=s_we_o=0 and gnt_o=00
//     before the next clk edge; after release, m0 wins a tie.
//   5 With ARB_TIMEOUT_EN and TIMEOUT=8, s_ack_i held 0 -> m0_err_o pulses 1 cycle,
//     8 cycles after stb; waiting m1 is granted on the next edge.
//   6 m1 drops cyc while s_ack_i=1 arrives in the same cycle -> m1_ack_o=0, no
//     spurious ack to m0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter.
//   - arb_state_e : arbiter FSM states (idle, master 0 owns, master 1 owns)
//   - ARB_*_DEFAULT : default address/data widths and timeout length
package wb_arb_pkg;

    localparam int unsigned ARB_AW_DEFAULT      = 16;
    localparam int unsigned ARB_DW_DEFAULT      = 8;
    localparam int unsigned ARB_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wb_arb_timeout.sv
// Bus-owner watchdog for wb_rr_arbiter. Compiled only when ARB_TIMEOUT_EN is defined.
// Counts cycles in which the owner strobes without an ack. Once the count has reached
// TIMEOUT-1 and the owner is still waiting, expired is raised for that cycle.
// Ports:
//   clk        in  system clock
//   reset_n    in  asynchronous active-low reset, clears the count
//   active     in  owner has cyc and stb high
//   ack        in  shared-bus ack
//   gnt_change in  grant moves on the next edge, restart counting
//   expired    out owner has waited too long; abort this cycle
`ifdef ARB_TIMEOUT_EN
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    input  logic ack,
    input  logic gnt_change,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    assign expired = active & ~ack & (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (!active || ack || gnt_change) begin
            count_d = '0;
        end else if (count_q != LAST) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`endif

// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter in front of a shared slave bus.
// The grant is registered and held while the owner keeps cyc high. The owner's
// adr/dat/we/stb/cyc are muxed onto the shared bus and the slave ack is returned
// to the owner only. Slave read data does not pass through this block.
// Optional feature macro: ARB_TIMEOUT_EN adds a stall watchdog that aborts the
// owner with a one-cycle err pulse after TIMEOUT cycles of stb without ack.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   m0_*_i / m1_*_i                  master adr, dat, we, stb, cyc
//   m0_ack_o, m1_ack_o               ack to the owning master
//   m0_err_o, m1_err_o               timeout abort (tied 0 without ARB_TIMEOUT_EN)
//   s_adr_o .. s_cyc_o               shared bus outputs
//   s_ack_i                          OR of all slave acks
//   gnt_o                            one-hot owner, 00 when idle
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned AW      = ARB_AW_DEFAULT,
    parameter int unsigned DW      = ARB_DW_DEFAULT,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic          m0_we_i,
    input  logic          m0_stb_i,
    input  logic          m0_cyc_i,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic          m1_we_i,
    input  logic          m1_stb_i,
    input  logic          m1_cyc_i,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic          s_we_o,
    output logic          s_stb_o,
    output logic          s_cyc_o,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o
);

    arb_state_e state_q, state_d;
    logic       last_gnt_q, last_gnt_d;  // index of the master granted most recently
    logic       req0, req1;
    logic       expired;

`ifdef ARB_TIMEOUT_EN
    // A master aborted by the watchdog stays masked until it drops cyc.
    logic blk0_q, blk1_q;
    logic owner_active;
    logic gnt_change;

    assign req0 = m0_cyc_i & ~blk0_q;
    assign req1 = m1_cyc_i & ~blk1_q;

    assign owner_active = ((state_q == ARB_OWN0) & m0_cyc_i & m0_stb_i)
                        | ((state_q == ARB_OWN1) & m1_cyc_i & m1_stb_i);
    assign gnt_change   = (state_d != state_q);

    wb_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .reset_n    (reset_n),
        .active     (owner_active),
        .ack        (s_ack_i),
        .gnt_change (gnt_change),
        .expired    (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk0_q <= 1'b0;
            blk1_q <= 1'b0;
        end else begin
            blk0_q <= (blk0_q | (expired & (state_q == ARB_OWN0))) & m0_cyc_i;
            blk1_q <= (blk1_q | (expired & (state_q == ARB_OWN1))) & m1_cyc_i;
        end
    end
`else
    logic unused_timeout;

    assign req0           = m0_cyc_i;
    assign req1           = m1_cyc_i;
    assign expired        = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (req0 && req1) begin
                    state_d = last_gnt_q ? ARB_OWN0 : ARB_OWN1;
                end else if (req0) begin
                    state_d = ARB_OWN0;
                end else if (req1) begin
                    state_d = ARB_OWN1;
                end
            end
            // Hand over directly to a waiting master: no idle cycle in between.
            ARB_OWN0: begin
                if (!m0_cyc_i || expired) begin
                    state_d = req1 ? ARB_OWN1 : ARB_IDLE;
                end
            end
            ARB_OWN1: begin
                if (!m1_cyc_i || expired) begin
                    state_d = req0 ? ARB_OWN0 : ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (state_d == ARB_OWN0 && state_q != ARB_OWN0) begin
            last_gnt_d = 1'b0;
        end else if (state_d == ARB_OWN1 && state_q != ARB_OWN1) begin
            last_gnt_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Shared-bus mux, combinational from the registered grant.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        unique case (state_q)
            ARB_OWN0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_we_o  = m0_we_i;
                s_cyc_o = m0_cyc_i & ~expired;
                s_stb_o = m0_cyc_i & m0_stb_i & ~expired;
            end
            ARB_OWN1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_we_o  = m1_we_i;
                s_cyc_o = m1_cyc_i & ~expired;
                s_stb_o = m1_cyc_i & m1_stb_i & ~expired;
            end
            default: ;
        endcase
    end

    assign gnt_o    = {state_q == ARB_OWN1, state_q == ARB_OWN0};
    assign m0_ack_o = s_ack_i & gnt_o[0] & m0_stb_i;
    assign m1_ack_o = s_ack_i & gnt_o[1] & m1_stb_i;
    assign m0_err_o = expired & gnt_o[0];
    assign m1_err_o = expired & gnt_o[1];

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic [DW-1:0] m0_dat, m1_dat, s_dat;
    logic          m0_we, m0_stb, m0_cyc, m0_ack, m0_err;
    logic          m1_we, m1_stb, m1_cyc, m1_ack, m1_err;
    logic          s_we, s_stb, s_cyc, s_ack;
    logic [1:0]    gnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0_adr_i (m0_adr),
        .m0_dat_i (m0_dat),
        .m0_we_i  (m0_we),
        .m0_stb_i (m0_stb),
        .m0_cyc_i (m0_cyc),
        .m0_ack_o (m0_ack),
        .m0_err_o (m0_err),
        .m1_adr_i (m1_adr),
        .m1_dat_i (m1_dat),
        .m1_we_i  (m1_we),
        .m1_stb_i (m1_stb),
        .m1_cyc_i (m1_cyc),
        .m1_ack_o (m1_ack),
        .m1_err_o (m1_err),
        .s_adr_o  (s_adr),
        .s_dat_o  (s_dat),
        .s_we_o   (s_we),
        .s_stb_o  (s_stb),
        .s_cyc_o  (s_cyc),
        .s_ack_i  (s_ack),
        .gnt_o    (gnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m0_adr = '0; m0_dat = '0; m0_we = 0; m0_stb = 0; m0_cyc = 0;
        m1_adr = '0; m1_dat = '0; m1_we = 0; m1_stb = 0; m1_cyc = 0;
        s_ack  = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1;
    endtask

    task automatic test_reset;
        idle_inputs();
        #1 reset_n = 0;
        #1;
        checks++;
        if (gnt !== 2'b00) begin
            failures++; $display("FAIL reset_gnt: got %b expected 00", gnt);
        end
        checks++;
        if ({s_cyc, s_stb, s_we, s_adr, s_dat} !== '0) begin
            failures++;
            $display("FAIL reset_bus: got cyc=%b stb=%b we=%b adr=%h dat=%h expected all 0",
                     s_cyc, s_stb, s_we, s_adr, s_dat);
        end
        s_ack = 1;
        #1;
        checks++;
        if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_acks: got %b expected 0000", {m0_ack, m1_ack, m0_err, m1_err});
        end
        s_ack = 0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1;
    endtask

    task automatic test_single_m0;
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'h1005; m0_dat = 8'h5a;
        #1;
        checks++;
        if (gnt !== 2'b00) begin
            failures++; $display("FAIL t1_pre_gnt: got %b expected 00", gnt);
        end
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            failures++; $display("FAIL t1_gnt: got %b expected 01", gnt);
        end
        checks++;
        if ({s_adr, s_dat, s_cyc, s_stb} !== {16'h1005, 8'h5a, 2'b11}) begin
            failures++;
            $display("FAIL t1_bus: got adr=%h dat=%h cyc=%b stb=%b expected 1005 5a 1 1",
                     s_adr, s_dat, s_cyc, s_stb);
        end
        s_ack = 1;
        #1;
        checks++;
        if ({m0_ack, m1_ack} !== 2'b10) begin
            failures++; $display("FAIL t1_ack: got m0=%b m1=%b expected 1 0", m0_ack, m1_ack);
        end
        idle_inputs();
        tick();
        checks++;
        if (gnt !== 2'b00) begin
            failures++; $display("FAIL t1_release: got %b expected 00", gnt);
        end
    endtask

    task automatic test_tie_handover;
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'h2000;
        m1_cyc = 1; m1_stb = 1; m1_adr = 16'h3000;
        tick();
        checks++;
        if ({gnt, s_adr} !== {2'b01, 16'h2000}) begin
            failures++; $display("FAIL t2_first: got gnt=%b adr=%h expected 01 2000", gnt, s_adr);
        end
        m0_cyc = 0; m0_stb = 0;
        tick();
        checks++;
        if ({gnt, s_adr} !== {2'b10, 16'h3000}) begin
            failures++; $display("FAIL t2_handover: got gnt=%b adr=%h expected 10 3000", gnt, s_adr);
        end
        idle_inputs();
        tick();
        checks++;
        if (gnt !== 2'b00) begin
            failures++; $display("FAIL t2_idle: got %b expected 00", gnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_gnt;
        do_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (gnt !== exp_gnt) begin
                failures++; $display("FAIL t3_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt);
            end
            s_ack = 1;
            #1;
            checks++;
            if ({m1_ack, m0_ack} !== exp_gnt) begin
                failures++;
                $display("FAIL t3_ack[%0d]: got %b expected %b", k, {m1_ack, m0_ack}, exp_gnt);
            end
            s_ack = 0;
            if (k % 2 == 0) begin m0_cyc = 0; m0_stb = 0; end
            else begin m1_cyc = 0; m1_stb = 0; end
            tick();
            if (k % 2 == 0) begin m0_cyc = 1; m0_stb = 1; end
            else begin m1_cyc = 1; m1_stb = 1; end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_write;
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 16'h4444; m1_dat = 8'hc3;
        tick();
        checks++;
        if ({gnt, s_we} !== 3'b101) begin
            failures++; $display("FAIL t4_owned: got gnt=%b we=%b expected 10 1", gnt, s_we);
        end
        #1 reset_n = 0;
        #1;
        checks++;
        if ({gnt, s_cyc, s_stb, s_we} !== 5'b00000) begin
            failures++;
            $display("FAIL t4_async: got gnt=%b cyc=%b stb=%b we=%b expected 00 0 0 0",
                     gnt, s_cyc, s_stb, s_we);
        end
        m0_cyc = 1; m0_stb = 1;
        #1 reset_n = 1;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            failures++; $display("FAIL t4_tie: got %b expected 01", gnt);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout;
        do_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 0;
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (m0_err !== (i == 8)) begin
                failures++; $display("FAIL t5_err[%0d]: got %b expected %b", i, m0_err, i == 8);
            end
            if (i == 8) begin
                checks++;
                if ({gnt, s_cyc, s_stb} !== 4'b0100) begin
                    failures++;
                    $display("FAIL t5_abort: got gnt=%b cyc=%b stb=%b expected 01 0 0",
                             gnt, s_cyc, s_stb);
                end
            end
            if (i == 9) begin
                checks++;
                if (gnt !== 2'b10) begin
                    failures++; $display("FAIL t5_next: got %b expected 10", gnt);
                end
            end
        end
        m1_cyc = 0; m1_stb = 0;
        tick();
        checks++;
        if (gnt !== 2'b00) begin
            failures++; $display("FAIL t5_blocked: got %b expected 00", gnt);
        end
        m0_cyc = 0; m0_stb = 0;
        tick();
        m0_cyc = 1; m0_stb = 1;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            failures++; $display("FAIL t5_rerequest: got %b expected 01", gnt);
        end
`else
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({gnt, m0_err, m1_err} !== 4'b0100) begin
                failures++;
                $display("FAIL hung_hold[%0d]: got gnt=%b err=%b%b expected 01 00",
                         i, gnt, m0_err, m1_err);
            end
        end
`endif
        idle_inputs();
        tick();
    endtask

    task automatic test_late_ack;
        do_reset();
        m1_cyc = 1; m1_stb = 1;
        tick();
        checks++;
        if (gnt !== 2'b10) begin
            failures++; $display("FAIL t6_gnt: got %b expected 10", gnt);
        end
        m1_cyc = 0; m1_stb = 0; s_ack = 1; m0_cyc = 1; m0_stb = 1;
        #1;
        checks++;
        if ({m0_ack, m1_ack} !== 2'b00) begin
            failures++; $display("FAIL t6_ack: got m0=%b m1=%b expected 0 0", m0_ack, m1_ack);
        end
        s_ack = 0;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            failures++; $display("FAIL t6_next: got %b expected 01", gnt);
        end
        idle_inputs();
        tick();
    endtask

    // Reference model: owner index (-1 = none), last granted index, stall count and
    // per-master abort lockout, advanced once per clock from the arbitration rules.
    task automatic test_random;
        int            owner, last, cnt, other, new_owner;
        bit            blk[2], req[2], c[2], s[2];
        bit            kill;
        logic [1:0]    e_gnt;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic          e_we, e_cyc, e_stb;
        logic [AW+DW+8:0] got, exp_v;
        do_reset();
        owner = -1; last = 1; cnt = 0; blk[0] = 0; blk[1] = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(3) == 0) m1_cyc = ~m1_cyc;
            m0_stb = m0_cyc & 1'($urandom_range(1));
            m1_stb = m1_cyc & 1'($urandom_range(1));
            m0_adr = AW'($urandom); m1_adr = AW'($urandom);
            m0_dat = DW'($urandom); m1_dat = DW'($urandom);
            m0_we  = 1'($urandom_range(1)); m1_we = 1'($urandom_range(1));
            s_ack  = ($urandom_range(3) == 0);
            #1;
            c[0] = m0_cyc; c[1] = m1_cyc; s[0] = m0_stb; s[1] = m1_stb;
            kill = TO_EN && owner >= 0 && c[owner] && s[owner] && !s_ack && cnt == TO - 1;
            e_adr = '0; e_dat = '0; e_we = 0; e_cyc = 0; e_stb = 0; e_gnt = 2'b00;
            if (owner == 0) begin
                e_gnt = 2'b01; e_adr = m0_adr; e_dat = m0_dat; e_we = m0_we;
            end else if (owner == 1) begin
                e_gnt = 2'b10; e_adr = m1_adr; e_dat = m1_dat; e_we = m1_we;
            end
            if (owner >= 0) begin
                e_cyc = c[owner] && !kill;
                e_stb = c[owner] && s[owner] && !kill;
            end
            exp_v = {e_gnt, e_adr, e_dat, e_we, e_stb, e_cyc,
                     s_ack && owner == 0 && m0_stb, s_ack && owner == 1 && m1_stb,
                     kill && owner == 0, kill && owner == 1};
            got   = {gnt, s_adr, s_dat, s_we, s_stb, s_cyc, m0_ack, m1_ack, m0_err, m1_err};
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL rand[%0d]: got %h expected %h (owner %0d)", i, got, exp_v, owner);
            end
            @(posedge clk);
            req[0] = c[0] && !blk[0];
            req[1] = c[1] && !blk[1];
            new_owner = owner;
            if (owner >= 0) begin
                if (kill || !c[owner]) begin
                    other = 1 - owner;
                    new_owner = req[other] ? other : -1;
                end
            end else if (req[0] && req[1]) begin
                new_owner = 1 - last;
            end else if (req[0]) begin
                new_owner = 0;
            end else if (req[1]) begin
                new_owner = 1;
            end
            if (new_owner >= 0 && new_owner != owner) last = new_owner;
            if (new_owner != owner) cnt = 0;
            else if (owner >= 0 && c[owner] && s[owner] && !s_ack) cnt++;
            else cnt = 0;
            for (int m = 0; m < 2; m++) blk[m] = (blk[m] || (kill && owner == m)) && c[m];
            owner = new_owner;
            #1;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single_m0();
        test_tie_handover();
        test_back_to_back();
        test_reset_mid_write();
        test_timeout();
        test_late_ack();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
